// File: rtl/immediate_decoder_pkg.sv
// JZJCoreFTypes: shared types and constants for the immediate decoder slice.
//   ImmediateFormat_t : RISC-V immediate encoding class of an instruction.
//   OPCODE_*          : major opcode constants (instruction[6:0]).
//   imm_entry_t       : one decoded result as held in the output/skid registers.
package JZJCoreFTypes;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } ImmediateFormat_t;

  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [31:0]      immediate;
    ImmediateFormat_t format;
    logic             illegal;
    logic [31:0]      target;
  } imm_entry_t;

  localparam imm_entry_t ResetEntry = '{
    immediate: 32'h0,
    format:    IMM_NONE,
    illegal:   1'b0,
    target:    32'h0
  };

endpackage

// File: rtl/immediate_decoder_if.sv
// immediate_decoder_if: upstream instruction handshake plus downstream decoded-result handshake.
//   slave  : the decoder (consumes inValid/instruction/pcOfInstruction/outReady).
//   master : the environment driving instructions and accepting results.
interface immediate_decoder_if;
  import JZJCoreFTypes::*;

  logic             inValid;
  logic             inReady;
  logic [31:0]      instruction;
  logic [31:0]      pcOfInstruction;
  logic             outValid;
  logic             outReady;
  logic [31:0]      immediate;
  ImmediateFormat_t immediateFormat;
  logic             illegalOpcode;
  logic [31:0]      target;

  modport slave (
    input  inValid, instruction, pcOfInstruction, outReady,
    output inReady, outValid, immediate, immediateFormat, illegalOpcode, target
  );

  modport master (
    output inValid, instruction, pcOfInstruction, outReady,
    input  inReady, outValid, immediate, immediateFormat, illegalOpcode, target
  );

endinterface

// File: rtl/immediate_decoder_extractor.sv
// immediate_extractor: purely combinational opcode decode and immediate extraction.
//   i_instruction : 32-bit RISC-V instruction word.
//   o_immediate   : sign/zero-formed immediate (0 for NONE).
//   o_format      : immediate encoding class.
//   o_illegal     : opcode not recognised.
module immediate_extractor
  import JZJCoreFTypes::*;
(
  input  logic [31:0]      i_instruction,
  output logic [31:0]      o_immediate,
  output ImmediateFormat_t o_format,
  output logic             o_illegal
);

  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_imm_i = {{20{i_instruction[31]}}, i_instruction[31:20]};
  assign w_imm_s = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
  assign w_imm_b = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                    i_instruction[30:25], i_instruction[11:8], 1'b0};
  assign w_imm_u = {i_instruction[31:12], 12'h000};
  assign w_imm_j = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                    i_instruction[20], i_instruction[30:21], 1'b0};

  always_comb begin
    o_format  = IMM_NONE;
    o_illegal = 1'b0;
    case (i_instruction[6:0])
      OPCODE_LUI, OPCODE_AUIPC:  o_format = IMM_U;
      OPCODE_JAL:                o_format = IMM_J;
      OPCODE_BRANCH:             o_format = IMM_B;
      OPCODE_STORE:              o_format = IMM_S;
      OPCODE_JALR, OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_MISC_MEM, OPCODE_SYSTEM:
                                 o_format = IMM_I;
      OPCODE_OP:                 o_format = IMM_NONE;
      default:                   o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    o_immediate = 32'h0;
    case (o_format)
      IMM_I:   o_immediate = w_imm_i;
      IMM_S:   o_immediate = w_imm_s;
      IMM_B:   o_immediate = w_imm_b;
      IMM_U:   o_immediate = w_imm_u;
      IMM_J:   o_immediate = w_imm_j;
      default: o_immediate = 32'h0;
    endcase
  end

endmodule

// File: rtl/immediate_decoder.sv
// immediate_decoder: decodes RISC-V immediates behind a two-entry (output + skid) buffer.
//   clock : sole clock, rising edge.
//   reset : synchronous active-high reset; discards buffered entries.
//   bus   : immediate_decoder_if.slave -- in handshake (inValid/inReady, instruction,
//           pcOfInstruction) and out handshake (outValid/outReady, immediate,
//           immediateFormat, illegalOpcode, target).
// Build option: define IMMEDIATE_DECODER_TARGET_EN to compute target = pc + immediate;
// otherwise target is constant 0 and pcOfInstruction is ignored.
module immediate_decoder
  import JZJCoreFTypes::*;
(
  input logic          clock,
  input logic          reset,
  immediate_decoder_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e     r_state;
  imm_entry_t r_out;
  imm_entry_t r_skid;
  logic       r_out_valid;
  logic       r_in_ready;

  logic [31:0]      w_immediate;
  ImmediateFormat_t w_format;
  logic             w_illegal;
  logic [31:0]      w_target;
  imm_entry_t       w_new;
  logic             w_in_fire;
  logic             w_out_fire;

  immediate_extractor u_extractor (
    .i_instruction (bus.instruction),
    .o_immediate   (w_immediate),
    .o_format      (w_format),
    .o_illegal     (w_illegal)
  );

`ifdef IMMEDIATE_DECODER_TARGET_EN
  assign w_target = bus.pcOfInstruction + w_immediate;
`else
  logic [31:0] w_unused_pc;
  assign w_unused_pc = bus.pcOfInstruction;
  assign w_target    = 32'h0;
`endif

  assign w_new = '{immediate: w_immediate, format: w_format, illegal: w_illegal,
                   target: w_target};

  assign w_in_fire  = bus.inValid & bus.inReady;
  assign w_out_fire = r_out_valid & bus.outReady;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StEmpty;
      r_out_valid <= 1'b0;
      // Preset so inReady is high in the first cycle after reset; masked while in reset.
      r_in_ready  <= 1'b1;
      r_out       <= ResetEntry;
      r_skid      <= ResetEntry;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            r_out       <= w_new;
            r_out_valid <= 1'b1;
            r_state     <= StOne;
          end
        end
        StOne: begin
          if (w_in_fire && w_out_fire) begin
            r_out <= w_new;
          end else if (w_in_fire) begin
            r_skid     <= w_new;
            r_in_ready <= 1'b0;
            r_state    <= StTwo;
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= StEmpty;
          end
        end
        StTwo: begin
          // inReady is low here, so only the drain case applies.
          if (w_out_fire) begin
            r_out      <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= StOne;
          end
        end
        default: begin
          r_state     <= StEmpty;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.inReady         = r_in_ready & ~reset;
  assign bus.outValid        = r_out_valid;
  assign bus.immediate       = r_out.immediate;
  assign bus.immediateFormat = r_out.format;
  assign bus.illegalOpcode   = r_out.illegal;
  assign bus.target          = r_out.target;

endmodule

// File: tb/tb_immediate_decoder.sv
// tb_immediate_decoder: scoreboard bench for immediate_decoder. Expected results are pushed
// when an input transfer is seen and compared when the DUT presents or transfers output.
module tb_immediate_decoder;
  import JZJCoreFTypes::*;

  typedef struct {
    logic [31:0]      imm;
    ImmediateFormat_t fmt;
    logic             ill;
    logic [31:0]      tgt;
  } exp_t;

  typedef struct {
    logic [31:0]      ins;
    logic [31:0]      pc;
    logic [31:0]      imm;
    ImmediateFormat_t fmt;
    logic             ill;
    logic [31:0]      tgt;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t cur_exp;
  bit   rand_mode = 1'b0;
  vec_t vecs[9];

  immediate_decoder_if bus ();

  immediate_decoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tgt_of(input logic [31:0] t);
`ifdef IMMEDIATE_DECODER_TARGET_EN
    return t;
`else
    return 32'h0 & t;
`endif
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e.ill = 1'b0;
    e.fmt = IMM_NONE;
    e.imm = 32'h0;
    case (ins[6:0])
      7'b0110111, 7'b0010111: begin e.fmt = IMM_U; e.imm = {ins[31:12], 12'b0}; end
      7'b1101111: begin
        e.fmt = IMM_J;
        e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1100011: begin
        e.fmt = IMM_B;
        e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0100011: begin e.fmt = IMM_S; e.imm = {{21{ins[31]}}, ins[30:25], ins[11:7]}; end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
        e.fmt = IMM_I;
        e.imm = {{21{ins[31]}}, ins[30:20]};
      end
      7'b0110011: e.fmt = IMM_NONE;
      default:    e.ill = 1'b1;
    endcase
    e.tgt = tgt_of(pc + e.imm);
    return e;
  endfunction

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.imm = v.imm;
    e.fmt = v.fmt;
    e.ill = v.ill;
    e.tgt = tgt_of(v.tgt);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e,
                      output int waited);
    bit got;
    got             = 1'b0;
    waited          = 0;
    bus.inValid         = 1'b1;
    bus.instruction     = ins;
    bus.pcOfInstruction = pc;
    cur_exp             = e;
    for (int k = 0; k < 64; k++) begin
      if (rand_mode) bus.outReady = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (bus.inReady) begin
        got = 1'b1;
        break;
      end
      waited++;
      @(posedge clock);
      #1;
    end
    if (!got) check("send_timeout", 32'(got), 32'h1);
    @(posedge clock);
    #1;
    bus.inValid = 1'b0;
  endtask

  task automatic send_vec(input int i, output int waited);
    send(vecs[i].ins, vecs[i].pc, from_vec(vecs[i]), waited);
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.outValid) begin
        if (sb.size() == 0) begin
          check("stale_valid", 32'(bus.outValid), 32'h0);
        end else begin
          check("immediate", bus.immediate, sb[0].imm);
          check("format", 32'(bus.immediateFormat), 32'(sb[0].fmt));
          check("illegal", 32'(bus.illegalOpcode), 32'(sb[0].ill));
          check("target", bus.target, sb[0].tgt);
          if (bus.outReady) void'(sb.pop_front());
        end
      end
      if (bus.inValid && bus.inReady) sb.push_back(cur_exp);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [31:0] r;
    logic [6:0] ops[12];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h33,
            7'h7F};
    vecs[0] = '{32'h12345037, 32'h0,    32'h12345000, IMM_U,    1'b0, 32'h12345000};
    vecs[1] = '{32'hFFF00093, 32'h10,   32'hFFFFFFFF, IMM_I,    1'b0, 32'h0000000F};
    vecs[2] = '{32'h0020A223, 32'h20,   32'h00000004, IMM_S,    1'b0, 32'h00000024};
    vecs[3] = '{32'h00000463, 32'h200,  32'h00000008, IMM_B,    1'b0, 32'h00000208};
    vecs[4] = '{32'hFFDFF06F, 32'h100,  32'hFFFFFFFC, IMM_J,    1'b0, 32'h000000FC};
    vecs[5] = '{32'hFFFFF017, 32'h1000, 32'hFFFFF000, IMM_U,    1'b0, 32'h00000000};
    vecs[6] = '{32'h0000007F, 32'h40,   32'h00000000, IMM_NONE, 1'b1, 32'h00000040};
    vecs[7] = '{32'h002081B3, 32'h50,   32'h00000000, IMM_NONE, 1'b0, 32'h00000050};
    vecs[8] = '{32'h00008067, 32'h60,   32'h00000000, IMM_I,    1'b0, 32'h00000060};

    reset               = 1'b1;
    bus.inValid         = 1'b0;
    bus.instruction     = 32'h0;
    bus.pcOfInstruction = 32'h0;
    bus.outReady        = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 32'(bus.outValid), 32'h0);
    check("rst_in_ready", 32'(bus.inReady), 32'h0);
    check("rst_immediate", bus.immediate, 32'h0);
    check("rst_target", bus.target, 32'h0);
    check("rst_format", 32'(bus.immediateFormat), 32'(IMM_NONE));
    check("rst_illegal", 32'(bus.illegalOpcode), 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("in_ready_after_reset", 32'(bus.inReady), 32'h1);
    check("valid_before_first", 32'(bus.outValid), 32'h0);
    @(posedge clock);
    #1 bus.outReady = 1'b1;

    // One-cycle latency on LUI.
    send_vec(0, w);
    @(negedge clock);
    check("latency_valid", 32'(bus.outValid), 32'h1);
    @(posedge clock);
    #1;

    // Back-to-back stream at full throughput.
    for (int i = 1; i < 9; i++) begin
      send_vec(i, w);
      check("throughput_wait", 32'(w), 32'h0);
    end
    repeat (3) @(posedge clock);
    #1 check("drain_stream", 32'(sb.size()), 32'h0);

    // Stall: second accept fills skid, inReady falls, outputs hold the first entry.
    bus.outReady = 1'b0;
    send_vec(3, w);
    send_vec(4, w);
    check("skid_accept_wait", 32'(w), 32'h0);
    repeat (2) begin
      @(negedge clock);
      check("stall_in_ready", 32'(bus.inReady), 32'h0);
      check("stall_hold_first", bus.immediate, 32'h00000008);
      @(posedge clock);
      #1;
    end
    bus.outReady = 1'b1;
    send_vec(5, w);
    repeat (4) @(posedge clock);
    #1 check("drain_three", 32'(sb.size()), 32'h0);

    // Reset while holding two entries.
    bus.outReady = 1'b0;
    send_vec(1, w);
    send_vec(2, w);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_two_valid", 32'(bus.outValid), 32'h0);
    check("reset_two_in_ready", 32'(bus.inReady), 32'h1);
    @(posedge clock);
    #1 bus.outReady = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    send_vec(6, w);
    repeat (3) @(posedge clock);
    #1 check("drain_after_reset", 32'(sb.size()), 32'h0);

    // Random instructions under random outReady.
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] pc;
      r  = $urandom;
      pc = $urandom;
      r[6:0] = ops[$urandom_range(0, 11)];
      send(r, pc, model(r, pc), w);
    end
    rand_mode    = 1'b0;
    bus.outReady = 1'b1;
    repeat (5) @(posedge clock);
    #1 check("drain_random", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/immediate_decoder.md
IMMEDIATE_DECODER -- requirements
Module: immediate_decoder

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports inValid (input, 1) and inReady (output, 1): upstream instruction handshake; transfer when both high at a clock edge.
REQ-004 SHALL have ports instruction (input, 32) and pcOfInstruction (input, 32), sampled on input transfer.
REQ-005 SHALL have ports outValid (output, 1) and outReady (input, 1): downstream handshake; transfer when both high.
REQ-006 SHALL have outputs immediate (32), immediateFormat (ImmediateFormat_t), illegalOpcode (1) and target (32), all registered and stable while outValid=1 and outReady=0.

Function
REQ-007 SHALL decode opcode instruction[6:0]: LUI 0110111 and AUIPC 0010111 as U; JAL 1101111 as J; BRANCH 1100011 as B; STORE 0100011 as S; JALR 1100111, LOAD 0000011, OP-IMM 0010011, MISC-MEM 0001111 and SYSTEM 1110011 as I; OP 0110011 as NONE.
REQ-008 SHALL form I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U = {inst[31:12],12'h000}; J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
REQ-009 SHALL output immediate 32'h0 for NONE; any other opcode gives format NONE, immediate 0, illegalOpcode=1; otherwise illegalOpcode=0.
REQ-010 SHALL compute target = pcOfInstruction + immediate, modulo 2^32 (carry discarded), for every format.
REQ-011 SHALL have latency of exactly one cycle: an instruction accepted at edge N is on the outputs with outValid=1 after edge N when the output register is free.
REQ-012 SHALL implement a two-entry buffer (output register plus skid register) with states EMPTY, ONE, TWO.
REQ-013 SHALL drive inReady = (state != TWO), from a register, not combinationally from outReady.
REQ-014 SHALL transition EMPTY->ONE on input transfer; ONE->EMPTY on output transfer without input; ONE->ONE on simultaneous input and output transfer (new entry loads output register); ONE->TWO on input transfer while outReady=0 (entry goes to skid); TWO->ONE on output transfer (skid moves to output register); otherwise hold.
REQ-015 SHALL deliver entries in acceptance order with no loss or duplication under any outReady pattern.
REQ-016 SHALL sustain one transfer per cycle when outReady is held high.

Reset
REQ-017 SHALL, while reset=1, force state EMPTY, outValid=0, inReady=0, immediate=0, target=0, immediateFormat=IMM_NONE, illegalOpcode=0; buffered entries are discarded.
REQ-018 SHALL, in the first cycle after reset deasserts, drive inReady=1; reset asserted mid-transfer cancels that transfer.

Configuration
REQ-019 SHALL compile the target adder only when IMMEDIATE_DECODER_TARGET_EN is defined; without it target is constant 0 and pcOfInstruction is unused; all other behaviour identical.

Structure
REQ-020 SHALL take ImmediateFormat_t {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} and the opcode constants from package JZJCoreFTypes.
REQ-021 SHALL place combinational opcode decode and immediate extraction in one sub-module, immediate_extractor; buffering and handshake stay in immediate_decoder.

Verification
REQ-022 SHALL test 0x12345037 (LUI) -> one cycle later outValid=1, immediate 0x12345000, format IMM_U, illegalOpcode 0.
REQ-023 SHALL test 0xFFF00093 (addi x1,x0,-1) -> 0xFFFFFFFF, IMM_I; 0x0020A223 (sw) -> 0x00000004, IMM_S; 0x00000463 (beq +8) at pc 0x200 -> 0x00000008, IMM_B, target 0x208.
REQ-024 SHALL test 0xFFDFF06F (jal -4) at pc 0x100 -> 0xFFFFFFFC, IMM_J, target 0xFC; 0xFFFFF017 (auipc) at pc 0x1000 -> target 0x00000000 (wrap).
REQ-025 SHALL test three back-to-back inputs with outReady=0 -> inReady falls after second accept, outputs hold first entry; raising outReady drains all three in order.
REQ-026 SHALL test opcode 0x7F -> IMM_NONE, immediate 0, illegalOpcode 1; and reset asserted in state TWO -> outValid 0 next cycle, no stale entry emerges afterwards.
REQ-027 SHALL test with IMMEDIATE_DECODER_TARGET_EN undefined -> target constantly 0, immediates unchanged.
